// File: rtl/sdram_mem_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_mem_arbiter
//
// Shares the single SDRAM controller request port between the instruction
// fetch (I) and data memory (D) requesters. Nothing is granted until the
// controller reports init complete. D has priority, but after MAX_WAIT
// consecutive D grants taken while I was waiting, I is forced through.
// Only one transaction is outstanding at a time.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   mem_init_done      SDRAM controller init complete
//   i_req/i_addr       fetch request (held until i_ack)
//   i_ack              one-cycle pulse: fetch request captured
//   i_rvalid/i_rdata   one-cycle pulse with fetch read data
//   d_req/d_we/d_addr/d_wdata/d_be
//                      data request (held until d_ack)
//   d_ack              one-cycle pulse: data request captured
//   d_rvalid/d_rdata   one-cycle pulse: data transaction done (rdata 0 for writes)
//   m_req/m_we/m_addr/m_wdata/m_be
//                      request to the SDRAM controller
//   m_ready            controller accepts m_req this cycle
//   m_done/m_rdata     controller transaction complete, read data
// ---------------------------------------------------------------------------
module sdram_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_init_done,

    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ack,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_ack,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,

    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_be,
    input  logic                  m_ready,
    input  logic                  m_done,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t           state, state_nxt;
    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_d, grant_i;

    // The controller request is asserted for exactly the ISSUE state; the
    // request fields come straight from the capture registers.
    assign m_req = (state == ISSUE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next state and grant decision
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_init_done) begin
                    // D wins unless I is waiting and has been starved too long.
                    if (d_req && !(i_req && starve_cnt >= CNT_MAX)) grant_d = 1'b1;
                    else if (i_req)                                  grant_i = 1'b1;
                    if (grant_d || grant_i) state_nxt = ISSUE;
                end
            end
            ISSUE: if (m_ready) state_nxt = WAIT;
            WAIT:  if (m_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Capture registers, handshake pulses, read data return, starvation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_be       <= '0;
            i_ack      <= 1'b0;
            i_rvalid   <= 1'b0;
            i_rdata    <= '0;
            d_ack      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
        end else begin
            // Pulses default low; they are raised only for a single cycle.
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;

            if (grant_d) begin
                owner   <= OWN_D;
                d_ack   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                m_be    <= d_be;
                // Only D wins taken while I waits count toward starvation.
                if (i_req && starve_cnt < CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
            end else if (grant_i) begin
                owner      <= OWN_I;
                i_ack      <= 1'b1;
                m_we       <= 1'b0;
                m_addr     <= i_addr;
                m_wdata    <= '0;
                m_be       <= {BE_W{1'b1}};
                starve_cnt <= '0;
            end

            if (state == WAIT && m_done) begin
                owner <= OWN_NONE;
                if (owner == OWN_I) begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= m_rdata;
                end else if (owner == OWN_D) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= m_we ? '0 : m_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_mem_arbiter
//
// Directed bench for sdram_mem_arbiter (default parameters, MAX_WAIT=8).
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at the same point, so every check sees the state left by the
// preceding edge. The SDRAM controller is played by hand: m_ready is
// given in the ISSUE cycle and m_done in the following cycle unless a step
// says otherwise.
// ---------------------------------------------------------------------------
module tb_sdram_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_init_done;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_ack, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_ready, m_done;
    logic [31:0] m_rdata;

    int checks   = 0;
    int failures = 0;

    sdram_mem_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_init_done (mem_init_done),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_ack         (i_ack),
        .i_rvalid      (i_rvalid),
        .i_rdata       (i_rdata),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_be          (d_be),
        .d_ack         (d_ack),
        .d_rvalid      (d_rvalid),
        .d_rdata       (d_rdata),
        .m_req         (m_req),
        .m_we          (m_we),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_be          (m_be),
        .m_ready       (m_ready),
        .m_done        (m_done),
        .m_rdata       (m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the ISSUE cycle: accept now, complete next cycle. Returns
    // in the cycle where rvalid is expected.
    task automatic run_mem(input logic [31:0] rdata);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        m_done  = 1'b1;
        m_rdata = rdata;
        tick();
        m_done  = 1'b0;
    endtask

    // Hard stop in case the bench itself gets stuck.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;

        rst_n = 1'b0; mem_init_done = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        m_ready = 1'b0; m_done = 1'b0; m_rdata = '0;
        #12;

        // ---- reset state
        check("rst_m_req",    m_req,    1'b0);
        check("rst_i_ack",    i_ack,    1'b0);
        check("rst_d_rvalid", d_rvalid, 1'b0);
        check("rst_m_be",     m_be,     4'h0);
        rst_n = 1'b1;
        tick();

        // ---- init gating: 20 cycles with I requesting, nothing granted
        i_req = 1'b1; i_addr = 32'h0000_0100;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            seen = seen | i_ack | m_req;
        end
        check("gate_no_grant", seen, 1'b0);

        mem_init_done = 1'b1;
        tick();
        check("i_ack",    i_ack,  1'b1);
        check("i_m_req",  m_req,  1'b1);
        check("i_m_addr", m_addr, 32'h100);
        check("i_m_we",   m_we,   1'b0);
        check("i_m_be",   m_be,   4'hF);
        i_req = 1'b0;

        // ---- I read: ready immediately, done 5 cycles later
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("i_ack_pulse", i_ack, 1'b0);
        check("i_wait_req",  m_req, 1'b0);
        tick(); tick(); tick(); tick();
        check("i_no_early_rvalid", i_rvalid, 1'b0);
        m_done = 1'b1; m_rdata = 32'h0000_0013;
        tick();
        m_done = 1'b0;
        check("i_rvalid",    i_rvalid, 1'b1);
        check("i_rdata",     i_rdata,  32'h13);
        check("i_d_rvalid0", d_rvalid, 1'b0);
        // m_done while IDLE must be ignored
        m_done = 1'b1; m_rdata = 32'hFFFF_FFFF;
        tick();
        m_done = 1'b0;
        check("i_rvalid_one", i_rvalid, 1'b0);
        check("idle_done_ign", i_rdata, 32'h13);
        check("idle_done_d",   d_rvalid, 1'b0);

        // ---- D write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        tick();
        d_req = 1'b0;
        check("dw_ack",   d_ack,   1'b1);
        check("dw_m_req", m_req,   1'b1);
        check("dw_m_we",  m_we,    1'b1);
        check("dw_addr",  m_addr,  32'h2000);
        check("dw_wdata", m_wdata, 32'hDEAD_BEEF);
        check("dw_be",    m_be,    4'b0011);
        run_mem(32'h1234_5678);
        check("dw_rvalid", d_rvalid, 1'b1);
        check("dw_rdata",  d_rdata,  32'h0);
        check("dw_i_rv",   i_rvalid, 1'b0);
        tick();
        check("dw_rvalid_one", d_rvalid, 1'b0);

        // ---- simultaneous requests: D first, I at the next IDLE
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'hF;
        tick();
        d_req = 1'b0;
        check("sim_d_ack", d_ack,  1'b1);
        check("sim_i_ack", i_ack,  1'b0);
        check("sim_addr",  m_addr, 32'h3000);
        run_mem(32'h0000_A5A5);
        check("sim_d_rvalid", d_rvalid, 1'b1);
        check("sim_d_rdata",  d_rdata,  32'hA5A5);
        tick();
        i_req = 1'b0;
        check("sim_i_ack2", i_ack,  1'b1);
        check("sim_i_addr", m_addr, 32'h100);
        run_mem(32'h0000_0077);
        check("sim_i_rdata", i_rdata, 32'h77);

        // ---- starvation: both held, expect D x8, then I, then D
        i_req = 1'b1; d_req = 1'b1; d_addr = 32'h4000;
        for (int g = 0; g < 10; g++) begin
            tick();
            check($sformatf("starve_i_ack_%0d", g), i_ack, (g == 8) ? 1'b1 : 1'b0);
            check($sformatf("starve_d_ack_%0d", g), d_ack, (g == 8) ? 1'b0 : 1'b1);
            if (g == 9) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            run_mem(32'h0000_0100 + 32'(g));
        end
        check("starve_last_rdata", d_rdata, 32'h109);

        // ---- init dropping while busy: finish current, grant nothing new
        tick();
        i_req = 1'b1; i_addr = 32'h0000_0200;
        tick();
        i_req = 1'b0;
        check("drop_i_ack", i_ack, 1'b1);
        mem_init_done = 1'b0;
        run_mem(32'h0000_0055);
        check("drop_rvalid", i_rvalid, 1'b1);
        check("drop_rdata",  i_rdata,  32'h55);
        i_req = 1'b1; d_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen = seen | i_ack | d_ack | m_req;
        end
        check("drop_no_grant", seen, 1'b0);
        i_req = 1'b0; d_req = 1'b0;
        mem_init_done = 1'b1;
        tick();

        // ---- reset in WAIT
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4444;
        tick();
        d_req = 1'b0;
        check("rw_d_ack", d_ack, 1'b1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rw_m_req",   m_req,   1'b0);
        check("rw_m_addr",  m_addr,  32'h0);
        check("rw_m_be",    m_be,    4'h0);
        check("rw_i_rdata", i_rdata, 32'h0);
        check("rw_d_rdata", d_rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        d_req = 1'b1; d_addr = 32'h5000;
        tick();
        d_req = 1'b0;
        check("post_d_ack",  d_ack,  1'b1);
        check("post_m_addr", m_addr, 32'h5000);
        check("post_m_we",   m_we,   1'b0);
        run_mem(32'hCAFE_F00D);
        check("post_d_rvalid", d_rvalid, 1'b1);
        check("post_d_rdata",  d_rdata,  32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_mem_arbiter.md
Name: sdram_mem_arbiter

Overview:
- Two-requester arbiter that shares the single SDRAM controller request port between instruction fetch (I) and data memory (D) inside the processor.
- Sits between the pipeline memory stages and the SDRAM controller.
- Gates all traffic until SDRAM init completes.
- Data-side priority, with a starvation counter that forces an I grant after MAX_WAIT consecutive D wins.

Parameters:
- ADDR_W, 32, byte address width on all ports
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_WAIT, 8, consecutive D grants with I pending before I is forced (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mem_init_done  in  1  SDRAM controller init complete
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  one-cycle pulse: I request captured
- i_rvalid  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_be  in  DATA_W/8  byte enables
- d_ack  out  1  one-cycle pulse: D request captured
- d_rvalid  out  1  one-cycle pulse: D transaction complete (read data valid if read)
- d_rdata  out  DATA_W  read data (0 for writes)
- m_req  out  1  request to SDRAM controller
- m_we  out  1  write
- m_addr  out  ADDR_W  address
- m_wdata  out  DATA_W  write data
- m_be  out  DATA_W/8  byte enables
- m_ready  in  1  controller accepts m_req this cycle
- m_done  in  1  controller transaction complete
- m_rdata  in  DATA_W  read data, valid with m_done

Behaviour:
- Reset values: all outputs 0; state IDLE; owner=none; starve_cnt=0.
- Outputs are registered, except m_* request fields, which are driven directly from the capture registers.
- States: IDLE, ISSUE, WAIT.
- IDLE: no grant while mem_init_done=0.
  - Otherwise, at the clock edge, the winner is chosen:
    - D if d_req && !(i_req && starve_cnt>=MAX_WAIT)
    - else I if i_req
  - On a grant: capture the winner's fields into the m_* registers; set owner; pulse the winner's ack in the next cycle; go to ISSUE.
  - An I capture forces m_we=0 and m_be=all ones.
- starve_cnt:
  - +1 on each D grant while i_req=1, saturating at MAX_WAIT.
  - Cleared on any I grant.
  - Unchanged otherwise.
- ISSUE: m_req=1; m_* fields are held stable. When m_req&&m_ready, go to WAIT and drop m_req next cycle.
- WAIT:
  - On m_done: pulse owner's rvalid for one cycle next cycle.
  - Owner's rdata = m_rdata for a read, 0 for a D write.
  - Return to IDLE.
- Non-owner rdata/rvalid are unchanged and 0 respectively.
- Handshake rules:
  - Requester must hold req and fields until it sees ack, then deassert req that cycle.
  - req is ignored outside IDLE.
  - Only one transaction is outstanding at a time.
- Latency: request captured at edge N; ack and m_req high in cycle N+1.
  - With m_ready in N+1 and m_done in N+2, rvalid is high in N+3.
  - Next grant earliest at edge N+3 (back-to-back throughput 1 transaction per 3 cycles minimum).
- Boundary conditions:
  - m_done in IDLE or ISSUE: ignored.
  - m_ready outside ISSUE: ignored.
  - mem_init_done falling while busy: current transaction completes; no new grants.
  - Simultaneous i_req/d_req with starve_cnt<MAX_WAIT: D wins.
- Reset mid-transaction: immediate return to reset values. The in-flight transaction is abandoned; the controller shares rst_n.

Test Plan:
- Init gating: mem_init_done=0, i_req=1 for 20 cycles -> i_ack=0, m_req=0 throughout. Raise mem_init_done -> i_ack pulse and m_req=1 on the following cycle.
- I read: i_addr=0x0000_0100, m_ready immediate, m_done 5 cycles later with m_rdata=0x0000_0013 -> m_addr=0x100, m_we=0, m_be=4'hF. Then i_rvalid high exactly one cycle with i_rdata=0x13; d_rvalid stays 0.
- D write: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011 -> m_* fields match while m_req=1. Then d_rvalid one-cycle pulse with d_rdata=0.
- Simultaneous i_req/d_req (starve_cnt=0) -> D granted first. I granted at the first IDLE after D's rvalid; starve_cnt then 0.
- Starvation: d_req and i_req held continuously, MAX_WAIT=8 -> exactly 8 D grants, then I grant, then D again.
- Reset mid-op: assert rst_n=0 while in WAIT -> all outputs 0 asynchronously. After release, a new d_req read completes normally with correct d_rdata.
